// File: rtl/fp_add_normalize.sv
// Post-adder normalize/round stage of the single-precision FP adder.
// Normalizes one bit per cycle, rounds to nearest-even, returns a packed word over valid/ready.
module fp_add_normalize #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [MAN_W:0]         iSum,
    input  logic                   iCarry,
    input  logic                   iGuard,
    input  logic                   iRound,
    input  logic                   iSticky,
    input  logic [EXP_W-1:0]       iExp,
    input  logic                   iSign,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [EXP_W+MAN_W:0]   oResult,
    output logic                   oOvf,
    output logic                   oUnf,
    output logic                   oInexact
);

    localparam int unsigned SUM_W   = MAN_W + 1;
    localparam int unsigned M_W     = MAN_W + 2;
    localparam int unsigned E_W     = EXP_W + 2;
    localparam int unsigned RES_W   = EXP_W + MAN_W + 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t               state, state_nxt;
    logic [M_W-1:0]       m, m_nxt;
    logic [E_W-1:0]       e, e_nxt;
    logic                 g, g_nxt, r, r_nxt, s, s_nxt;
    logic                 z, z_nxt, sign, sign_nxt;
    logic                 valid_q, valid_nxt;
    logic [RES_W-1:0]     result_q, result_nxt;
    logic                 ovf_q, ovf_nxt, unf_q, unf_nxt, inexact_q, inexact_nxt;

    logic                 rnd_up;
    logic [SUM_W:0]       sum_ext;
    logic [SUM_W-1:0]     man_r;
    logic [E_W-1:0]       e_r;
    logic [EXP_W-1:0]     exp_field;

    assign oReady   = (state == IDLE) && !iRst;
    assign oValid   = valid_q;
    assign oResult  = result_q;
    assign oOvf     = ovf_q;
    assign oUnf     = unf_q;
    assign oInexact = inexact_q;

    // Next-state, datapath and output logic
    always_comb begin
        state_nxt   = state;
        m_nxt       = m;
        e_nxt       = e;
        g_nxt       = g;
        r_nxt       = r;
        s_nxt       = s;
        z_nxt       = z;
        sign_nxt    = sign;
        valid_nxt   = valid_q;
        result_nxt  = result_q;
        ovf_nxt     = ovf_q;
        unf_nxt     = unf_q;
        inexact_nxt = inexact_q;
        rnd_up      = 1'b0;
        sum_ext     = '0;
        man_r       = '0;
        e_r         = e;
        exp_field   = '0;

        case (state)
            IDLE: begin
                if (iValid) begin
                    m_nxt     = {iCarry, iSum};
                    e_nxt     = (iExp == '0) ? E_W'(1) : E_W'(iExp);
                    g_nxt     = iGuard;
                    r_nxt     = iRound;
                    s_nxt     = iSticky;
                    sign_nxt  = iSign;
                    z_nxt     = ({iCarry, iSum} == '0) && !iGuard && !iRound && !iSticky;
                    state_nxt = NORM;
                end
            end

            NORM: begin
                if (z) begin
                    state_nxt = ROUND;
                end else if (m[M_W-1]) begin
                    m_nxt     = m >> 1;
                    g_nxt     = m[0];
                    r_nxt     = g;
                    s_nxt     = r | s;
                    e_nxt     = e + E_W'(1);
                    state_nxt = ROUND;
                end else if (m[M_W-2] || (e == E_W'(1))) begin
                    state_nxt = ROUND;
                end else begin
                    m_nxt = {m[M_W-2:0], g};
                    g_nxt = r;
                    r_nxt = 1'b0;
                    e_nxt = e - E_W'(1);
                end
            end

            ROUND: begin
                // Round to nearest, ties to even
                rnd_up  = g & (r | s | m[0]);
                sum_ext = {1'b0, m[SUM_W-1:0]} + (SUM_W+1)'(rnd_up);
                if (sum_ext[SUM_W]) begin
                    man_r = {1'b1, {(SUM_W-1){1'b0}}};
                    e_r   = e + E_W'(1);
                end else begin
                    man_r = sum_ext[SUM_W-1:0];
                    e_r   = e;
                end
                exp_field = ((e_r == E_W'(1)) && !man_r[SUM_W-1]) ? '0 : e_r[EXP_W-1:0];

                if (z) begin
                    result_nxt  = '0;
                    ovf_nxt     = 1'b0;
                    unf_nxt     = 1'b0;
                    inexact_nxt = 1'b0;
                end else if (e_r >= E_W'(EXP_MAX)) begin
                    result_nxt  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_nxt     = 1'b1;
                    unf_nxt     = 1'b0;
                    inexact_nxt = g | r | s;
                end else begin
                    result_nxt  = {sign, exp_field, man_r[MAN_W-1:0]};
                    ovf_nxt     = 1'b0;
                    unf_nxt     = (exp_field == '0) && (man_r[MAN_W-1:0] != '0);
                    inexact_nxt = g | r | s;
                end
                valid_nxt = 1'b1;
                state_nxt = DONE;
            end

            DONE: begin
                if (iReady) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            m         <= '0;
            e         <= '0;
            g         <= 1'b0;
            r         <= 1'b0;
            s         <= 1'b0;
            z         <= 1'b0;
            sign      <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            m         <= m_nxt;
            e         <= e_nxt;
            g         <= g_nxt;
            r         <= r_nxt;
            s         <= s_nxt;
            z         <= z_nxt;
            sign      <= sign_nxt;
            valid_q   <= valid_nxt;
            result_q  <= result_nxt;
            ovf_q     <= ovf_nxt;
            unf_q     <= unf_nxt;
            inexact_q <= inexact_nxt;
        end
    end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Post-adder stage of the single-precision floating-point adder.
- Consumes the 24-bit mantissa sum and carry-out from the 24-bit carry-lookahead adder, plus the aligned exponent, sign and guard/round/sticky bits from the alignment stage.
- Normalizes iteratively, one bit per cycle, then rounds to nearest-even.
- Emits a packed IEEE-754 single-precision word over a valid/ready handshake.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (sum input width = MAN_W+1)

Ports:
iClk  input  1  clock, rising edge
iRst  input  1  synchronous active-high reset
iValid  input  1  upstream data valid
oReady  output  1  block can accept (high only in IDLE and iRst low)
iSum  input  24  mantissa sum from the adder
iCarry  input  1  adder carry-out
iGuard  input  1  guard bit from alignment
iRound  input  1  round bit from alignment
iSticky  input  1  OR of remaining shifted-out bits
iExp  input  8  biased exponent of larger operand; 0 is treated as 1
iSign  input  1  result sign
oValid  output  1  result valid
iReady  input  1  downstream accepts result
oResult  output  32  {sign, exp[7:0], frac[22:0]}
oOvf  output  1  result overflowed to infinity
oUnf  output  1  result nonzero with exponent field 0
oInexact  output  1  any of G/R/S nonzero at rounding

Behaviour:
- Internal registers:
  - M: 25-bit, {carry, sum}
  - E: 10-bit unsigned
  - G, R, S: guard/round/sticky
  - Zero flag Z
- FSM states: IDLE, NORM, ROUND, DONE.
- Reset (sync): state=IDLE; oValid=0; oResult=0; oOvf=0; oUnf=0; oInexact=0. oReady=0 while iRst=1.
- IDLE:
  - On iValid&oReady: latch M={iCarry,iSum}, E=max(iExp,1), G, R, S, sign.
  - Z=1 if M, G, R and S are all zero.
  - Go to NORM.
- NORM (one action per cycle):
  - If Z: go ROUND.
  - Else if M[24]=1: right shift by 1, then go ROUND.
    - M=M>>1; G=old M[0]; R=old G; S=old R|old S; E=E+1.
  - Else if M[23]=1 or E==1: go ROUND, no shift.
  - Else: left shift by 1, stay in NORM.
    - M={M[23:0],G}; G=R; R=0; S unchanged; E=E-1.
- ROUND:
  - up=G&(R|S|M[0]); M24=M[23:0]+up.
  - If the add carries out of 24 bits: M24=0x800000 and E=E+1.
  - Else if E==1 and M24[23]=0: exponent field=0 (subnormal).
  - If E>=255: oResult={sign,8'hFF,23'h0}, oOvf=1.
  - Else: oResult={sign,E[7:0] or 0 if subnormal,M24[22:0]}.
  - Z forces oResult=32'h00000000 (+0).
  - oInexact=G|R|S (0 when Z).
  - oUnf=exponent field 0 and fraction nonzero.
  - Go DONE.
- DONE:
  - oValid=1. oResult and flags hold stable until iValid... (handshake is iReady): hold until iReady=1.
  - On oValid&iReady: oValid=0 next cycle; go IDLE.
  - No new accept in the same cycle.
- Latency, counted from the accept edge to oValid high: 3 edges plus k, where k = number of left shifts (0..23). Right shift and zero cases take 3 edges.
- Throughput: one operation in flight; oReady=0 outside IDLE.
- iRst mid-operation: the in-flight operation is dropped. Next cycle: IDLE, oValid=0, oReady=1 (once iRst deasserts).
- Inputs are ignored outside IDLE.

Test Plan:
1. Already normalized: iSum=0x800000, iCarry=0, iExp=0x7F, GRS=000, sign=0 -> oResult=0x3F800000, oValid 3 edges after accept, all flags 0.
2. Carry-out: iCarry=1, iSum=0x000000, iExp=0x7F -> oResult=0x40000000. Second case: iExp=0xFE -> 0x7F800000, oOvf=1.
3. Long normalize: iSum=0x000001, iExp=0x7F -> 23 shifts, oResult=0x34000000, latency 26. Subnormal case: iSum=0x000001, iExp=0x02 -> oResult=0x00000002, oUnf=1.
4. Rounding:
   - iSum=0x800000, G=1, R=0, S=0 -> 0x3F800000 (tie to even, down), oInexact=1.
   - iSum=0x800001, G=1 -> 0x3F800002.
   - iSum=0xFFFFFF, iExp=0x7F, G=1 -> 0x40000000.
5. Zero: iSum=0, iCarry=0, GRS=000, iSign=1 -> oResult=0x00000000, latency 3.
6. Handshake/reset:
   - Hold iReady=0 for 5 cycles in DONE -> oResult and oValid stable, oReady=0.
   - Pulse iRst during NORM of case 3 -> oValid=0 and oReady=1 next cycle, with no stale result emitted.
